bist_response_analyzer: RTL

- Output-response analyzer for test-per-scan BIST: the receiving end of the scan path the pattern generator drives.
- Compacts scan-out bits from SCAN_WIDTH parallel chains into a multiple-input signature register (MISR) over NUM_PATTERNS unloads.
- Compares the final signature against a golden value and reports pass_nfail/done to the BIST controller.

---
 rtl/bist_response_analyzer_if.sv | 27 ++
 rtl/bist_response_analyzer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/bist_response_analyzer_if.sv
// Signal bundle between the BIST controller / scan path and the response analyzer.
// The controller drives start, shift_en and scan_out; the analyzer returns status and the signature.
interface bist_response_analyzer_if #(
  parameter int SCAN_WIDTH = 2,
  parameter int MISR_WIDTH = 16,
  parameter int CNT_W      = 7
);
  logic                  start;
  logic                  shift_en;
  logic [SCAN_WIDTH-1:0] scan_out;
  logic                  busy;
  logic                  done;
  logic                  pass_nfail;
  logic [MISR_WIDTH-1:0] signature;
  logic [CNT_W-1:0]      pattern_cnt;
  logic [2:0]            fsm_state;

  modport master (
    output start, shift_en, scan_out,
    input  busy, done, pass_nfail, signature, pattern_cnt, fsm_state
  );

  modport slave (
    input  start, shift_en, scan_out,
    output busy, done, pass_nfail, signature, pattern_cnt, fsm_state
  );
endinterface

// File: rtl/bist_response_analyzer.sv
// Test-per-scan output-response analyzer: compacts scan-out bits into a MISR over
// NUM_PATTERNS unloads, then compares the signature with GOLDEN.
// Handshake: start is a one-cycle pulse honoured only when not busy; scan_out is
// consumed on every cycle with shift_en=1 while compacting; done/pass_nfail hold until
// the next start or reset.
module bist_response_analyzer #(
  parameter int                    SCAN_WIDTH   = 2,
  parameter int                    MISR_WIDTH   = 16,
  parameter logic [MISR_WIDTH-1:0] MISR_POLY    = 16'h002D,
  parameter logic [MISR_WIDTH-1:0] MISR_SEED    = 16'h0000,
  parameter logic [MISR_WIDTH-1:0] GOLDEN       = 16'h0000,
  parameter int                    CHAIN_LEN    = 32,
  parameter int                    NUM_PATTERNS = 100,
  parameter int                    SKIP_FIRST   = 1
) (
  input logic clock,
  input logic reset,
  bist_response_analyzer_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_PATTERNS + 2);
  localparam int BIT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SKIP    = 3'd1,
    COMPACT = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [MISR_WIDTH-1:0] sig_q, sig_n;
  logic [BIT_W-1:0]      bit_cnt, bit_n;
  logic [CNT_W-1:0]      pcnt_q, pcnt_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic                  pass_q, pass_n;

  logic                  last_bit;
  logic [CNT_W-1:0]      pcnt_inc;
  logic [MISR_WIDTH-1:0] misr_next;

  assign last_bit = (bit_cnt == BIT_W'(CHAIN_LEN - 1));
  assign pcnt_inc = pcnt_q + 1'b1;
  // Shift left with polynomial feedback from the MSB, then fold in all chains at once.
  assign misr_next = ({sig_q[MISR_WIDTH-2:0], 1'b0} ^ (sig_q[MISR_WIDTH-1] ? MISR_POLY : '0))
                     ^ MISR_WIDTH'(bus.scan_out);

  always_comb begin
    state_n = state;
    sig_n   = sig_q;
    bit_n   = bit_cnt;
    pcnt_n  = pcnt_q;
    busy_n  = busy_q;
    done_n  = done_q;
    pass_n  = pass_q;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          sig_n   = MISR_SEED;
          bit_n   = '0;
          pcnt_n  = '0;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          busy_n  = 1'b1;
          state_n = (SKIP_FIRST != 0) ? SKIP : COMPACT;
        end
      end
      SKIP: begin
        // The first unload holds whatever was in the chains before any pattern.
        if (bus.shift_en) begin
          if (last_bit) begin
            bit_n   = '0;
            pcnt_n  = CNT_W'(1);
            state_n = COMPACT;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      COMPACT: begin
        if (bus.shift_en) begin
          sig_n = misr_next;
          if (last_bit) begin
            bit_n  = '0;
            pcnt_n = pcnt_inc;
            if (pcnt_inc == CNT_W'(NUM_PATTERNS + SKIP_FIRST)) state_n = CHECK;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      CHECK: begin
        pass_n  = (sig_q == GOLDEN);
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sig_q   <= MISR_SEED;
      bit_cnt <= '0;
      pcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state   <= state_n;
      sig_q   <= sig_n;
      bit_cnt <= bit_n;
      pcnt_q  <= pcnt_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      pass_q  <= pass_n;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass_nfail  = pass_q;
  assign bus.signature   = sig_q;
  assign bus.pattern_cnt = pcnt_q;
  assign bus.fsm_state   = state;
endmodule
